ie_muldiv_unit: RTL and testbench
=================================

IE_MULDIV_UNIT -- requirements
Module: ie_muldiv_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter: DIV_STEPS, default 32, divide iterations; SHALL equal DATA_WIDTH.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_Start_E  input  1  RV32M instruction present in Execute this cycle.
REQ-006 i_Funct3_E  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 i_SrcA_E  input  DATA_WIDTH  rs1 operand (post-forwarding).
REQ-008 i_SrcB_E  input  DATA_WIDTH  rs2 operand (post-forwarding).
REQ-009 i_Flush  input  1  Execute-stage flush (same source as the ID/IE register clear).
REQ-010 o_Busy  output  1  stall request to hazard unit; freezes PC, IF/ID and ID/IE.
REQ-011 o_Done  output  1  one-cycle pulse, o_Result_E valid.
REQ-012 o_Result_E  output  DATA_WIDTH  M-op result to the EX/MEM register.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-014 IDLE: i_Start_E=1 and i_Funct3_E[2]=0 -> MUL; i_Start_E=1 and i_Funct3_E[2]=1 -> DIV; else stay; operands and funct3 latched on the accepting edge.
REQ-015 MUL: full 2*DATA_WIDTH product computed from latched operands (signedness per funct3), low half for MUL, high half otherwise, registered; -> DONE after one cycle.
REQ-016 DIV: restoring radix-2 on operand magnitudes, one quotient bit per cycle, 5-bit step counter 0..DIV_STEPS-1; -> DONE when counter = DIV_STEPS-1.
REQ-017 Latency: start sampled at edge T; MUL ops o_Done high in cycle T+2; DIV/REM ops o_Done high in cycle T+33; latency independent of operand values.
REQ-018 Signed DIV/REM: quotient negated when operand signs differ; remainder takes dividend sign; correction applied on entry to DONE.
REQ-019 Divide by zero: quotient = all ones, remainder = dividend (DIV, DIVU, REM, REMU).
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
REQ-021 o_Busy = (state=IDLE and i_Start_E) or state in {MUL, DIV}; combinational, low in DONE.
REQ-022 DONE: o_Done=1 for exactly one cycle; -> IDLE unconditionally; i_Start_E ignored in DONE.
REQ-023 o_Result_E SHALL hold its last value from DONE until the next DONE.
REQ-024 i_Flush=1 in any state -> IDLE next edge; no o_Done pulse; o_Result_E unchanged; flush beats a simultaneous start.
REQ-025 Back-to-back M-ops: the second is accepted from IDLE in the cycle after DONE.
REQ-026 i_Funct3_E is sampled only on the accepting edge; changes during MUL/DIV have no effect.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, all operand/partial registers 0, o_Result_E=0, o_Done=0.
REQ-028 o_Busy SHALL be 0 during reset regardless of i_Start_E.
REQ-029 Reset mid-operation SHALL abandon the op; no o_Done after release.

Structure
REQ-030 Shared package riscv_pkg SHALL hold DATA_WIDTH, M-extension funct3 encodings and the FSM state encoding.
REQ-031 One sub-module, ie_div_step: combinational single restoring step (remainder, quotient in -> remainder, quotient out); instantiated once.

Verification
REQ-032 MUL 7 x 0xFFFFFFFD (-3), start at edge T -> o_Result_E=0xFFFFFFEB, o_Done in cycle T+2, o_Busy high in cycles T and T+1 only.
REQ-033 A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; o_Done exactly in cycle T+33; DIVU 100/7 -> 14, REMU -> 2.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-036 i_Flush at DIV step 10 -> IDLE next cycle, o_Busy low, no o_Done, o_Result_E keeps prior value; repeat with rst -> all outputs 0 immediately.
REQ-037 MUL followed by DIV with i_Start_E held: DIV accepted the cycle after MUL DONE; both o_Done pulses seen with correct results.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: datapath width, M-extension funct3 codes and the
// multiply/divide FSM state encoding.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/ie_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift in the quotient bit.
module ie_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_i < divisor_i always holds, so diff's top bit is a clean borrow flag.
  assign shifted = {rem_i, quo_i[W-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  always_comb begin
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ie_muldiv_unit.sv
// Execute-stage RV32M unit: single-cycle registered multiply and a radix-2
// restoring divider, stalling the pipeline through o_Busy while it works.
module ie_muldiv_unit #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int DIV_STEPS  = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start_E,
  input  logic [2:0]            i_Funct3_E,
  input  logic [DATA_WIDTH-1:0] i_SrcA_E,
  input  logic [DATA_WIDTH-1:0] i_SrcB_E,
  input  logic                  i_Flush,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_Result_E
);
  import riscv_pkg::*;

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DIV_STEPS);

  md_state_e      state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0]   result_q, result_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic           div_signed, start_signed, a_signed, b_signed, pick_quo;
  logic [W-1:0]   divisor_mag, start_a_mag;
  logic [W-1:0]   step_rem, step_quo, q_fix, r_fix, div_result;
  logic [2*W-1:0] a_ext, b_ext, product;

  assign div_signed   = (funct3_q == F3_DIV) || (funct3_q == F3_REM);
  assign start_signed = (i_Funct3_E == F3_DIV) || (i_Funct3_E == F3_REM);
  assign pick_quo     = (funct3_q == F3_DIV) || (funct3_q == F3_DIVU);
  assign divisor_mag  = (div_signed && op_b_q[W-1]) ? -op_b_q : op_b_q;
  assign start_a_mag  = (start_signed && i_SrcA_E[W-1]) ? -i_SrcA_E : i_SrcA_E;

  ie_div_step #(.W(W)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_mag),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Sign fix-up; a zero divisor keeps the all-ones quotient un-negated.
  assign q_fix = (div_signed && (op_a_q[W-1] ^ op_b_q[W-1]) && (|op_b_q))
                 ? -step_quo : step_quo;
  assign r_fix = (div_signed && op_a_q[W-1]) ? -step_rem : step_rem;
  assign div_result = pick_quo ? q_fix : r_fix;

  assign a_signed = (funct3_q == F3_MUL) || (funct3_q == F3_MULH) || (funct3_q == F3_MULHSU);
  assign b_signed = (funct3_q == F3_MUL) || (funct3_q == F3_MULH);
  assign a_ext    = a_signed ? {{W{op_a_q[W-1]}}, op_a_q} : {{W{1'b0}}, op_a_q};
  assign b_ext    = b_signed ? {{W{op_b_q[W-1]}}, op_b_q} : {{W{1'b0}}, op_b_q};
  assign product  = a_ext * b_ext;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    funct3_d = funct3_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start_E) begin
          op_a_d   = i_SrcA_E;
          op_b_d   = i_SrcB_E;
          funct3_d = i_Funct3_E;
          rem_d    = '0;
          quo_d    = start_a_mag;
          cnt_d    = '0;
          state_d  = i_Funct3_E[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        result_d = (funct3_q == F3_MUL) ? product[W-1:0] : product[2*W-1:W];
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          result_d = div_result;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything, including a start in the same cycle.
    if (i_Flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      funct3_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      funct3_q <= funct3_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign o_Busy     = !rst && (((state_q == ST_IDLE) && i_Start_E) ||
                               (state_q == ST_MUL) || (state_q == ST_DIV));
  assign o_Done     = (state_q == ST_DONE);
  assign o_Result_E = result_q;

endmodule

// File: tb/tb_ie_muldiv_unit.sv
// Self-checking bench for ie_muldiv_unit: directed RV32M corner cases, random
// operations against an arithmetic reference model, flush/reset abandonment.
module tb_ie_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Start_E;
  logic [2:0]  i_Funct3_E;
  logic [31:0] i_SrcA_E;
  logic [31:0] i_SrcB_E;
  logic        i_Flush;
  logic        o_Busy;
  logic        o_Done;
  logic [31:0] o_Result_E;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_last = 32'h0;

  always #5 clk = ~clk;

  ie_muldiv_unit #(.DATA_WIDTH(32), .DIV_STEPS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_Start_E  (i_Start_E),
    .i_Funct3_E (i_Funct3_E),
    .i_SrcA_E   (i_SrcA_E),
    .i_SrcB_E   (i_SrcB_E),
    .i_Flush    (i_Flush),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Result_E (o_Result_E)
  );

  // Reference: RV32M semantics from 64-bit arithmetic and language division.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic signed [31:0] q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Called just after a rising edge: presents the op in that cycle (cycle 0)
  // and reports the cycle index of o_Done and how many cycles o_Busy was high.
  task automatic do_op(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb,
                       input bit keep, output logic [31:0] res, output int lat,
                       output int busy_n);
    bit waiting;
    i_Start_E  = 1'b1;
    i_Funct3_E = f;
    i_SrcA_E   = va;
    i_SrcB_E   = vb;
    lat = -1;
    busy_n = 0;
    res = 32'hx;
    waiting = 1'b1;
    for (int c = 0; c < 60 && waiting; c++) begin
      @(negedge clk);
      if (o_Busy) busy_n++;
      if (o_Done) begin
        lat = c;
        res = o_Result_E;
        waiting = 1'b0;
      end else begin
        @(posedge clk); #1;
        // Inputs after acceptance must not matter.
        i_Funct3_E = 3'($urandom);
        i_SrcA_E   = $urandom;
        i_SrcB_E   = $urandom;
      end
    end
    @(posedge clk); #1;
    if (!keep) i_Start_E = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_Start_E = 1'b1; i_Flush = 1'b0;
    i_Funct3_E = 3'd4; i_SrcA_E = 32'd9; i_SrcB_E = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (o_Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
    tests_run++;
    if (o_Done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", o_Done); end
    tests_run++;
    if (o_Result_E !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", o_Result_E); end
    @(posedge clk); #1;
    rst = 1'b0; i_Start_E = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset: busy %b done %b expected 0 0", o_Busy, o_Done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_directed();
    logic [31:0] res;
    int lat, bn;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, res, lat, bn);
    tests_run++;
    if (res !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_7x-3: got %h expected ffffffeb", res); end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL mul_latency: got %0d expected 2", lat); end
    tests_run++;
    if (bn !== 2) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d expected 2", bn); end
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bn);
    tests_run++;
    if (res !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mulhu_ones: got %h expected fffffffe", res); end
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bn);
    tests_run++;
    if (res !== 32'h0) begin tests_failed++; $display("FAIL mulh_ones: got %h expected 00000000", res); end
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bn);
    tests_run++;
    if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mulhsu_ones: got %h expected ffffffff", res); end
    exp_last = 32'hFFFF_FFFF;
  endtask

  task automatic test_div_directed();
    logic [31:0] res;
    int lat, bn;
    logic [2:0]  f_t[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] a_t[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b_t[8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e_t[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                            32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    for (int i = 0; i < 8; i++) begin
      do_op(f_t[i], a_t[i], b_t[i], 1'b0, res, lat, bn);
      tests_run++;
      if (res !== e_t[i]) begin
        tests_failed++; $display("FAIL div_directed_%0d: got %h expected %h", i, res, e_t[i]);
      end
      tests_run++;
      if (lat !== 33) begin tests_failed++; $display("FAIL div_latency_%0d: got %0d expected 33", i, lat); end
      tests_run++;
      if (bn !== 33) begin tests_failed++; $display("FAIL div_busy_cycles_%0d: got %0d expected 33", i, bn); end
    end
    exp_last = e_t[7];
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, e;
    logic [2:0] f;
    int lat, bn, elat;
    logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      e = ref_model(f, a, b);
      elat = f[2] ? 33 : 2;
      do_op(f, a, b, 1'b0, res, lat, bn);
      tests_run++;
      if (res !== e) begin
        tests_failed++; $display("FAIL rand_%0d_f%0d: a %h b %h got %h expected %h", i, f, a, b, res, e);
      end
      tests_run++;
      if (lat !== elat) begin tests_failed++; $display("FAIL rand_latency_%0d: got %0d expected %0d", i, lat, elat); end
      @(negedge clk);
      tests_run++;
      if (o_Result_E !== e) begin
        tests_failed++; $display("FAIL rand_hold_%0d: got %h expected %h", i, o_Result_E, e);
      end
      exp_last = e;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_reset();
    int dones;
    i_Start_E = 1'b1; i_Funct3_E = 3'd5; i_SrcA_E = 32'd1000; i_SrcB_E = 32'd3;
    repeat (11) begin @(posedge clk); #1; end
    i_Start_E = 1'b0; i_Flush = 1'b1;
    @(posedge clk); #1;
    i_Flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_Busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b expected 0", o_Busy); end
    tests_run++;
    if (o_Result_E !== exp_last) begin
      tests_failed++; $display("FAIL flush_result_kept: got %h expected %h", o_Result_E, exp_last);
    end
    // Start colliding with flush must not be accepted either.
    @(posedge clk); #1;
    i_Start_E = 1'b1; i_Flush = 1'b1; i_Funct3_E = 3'd0;
    @(posedge clk); #1;
    i_Start_E = 1'b0; i_Flush = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (o_Done) dones++; end
    tests_run++;
    if (dones !== 0) begin tests_failed++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones); end
    tests_run++;
    if (o_Result_E !== exp_last) begin
      tests_failed++; $display("FAIL flush_start_result: got %h expected %h", o_Result_E, exp_last);
    end
    @(posedge clk); #1;
    i_Start_E = 1'b1; i_Funct3_E = 3'd4; i_SrcA_E = 32'd77; i_SrcB_E = 32'd5;
    repeat (11) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests_run++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_Result_E !== 32'h0) begin
      tests_failed++;
      $display("FAIL midop_reset: busy %b done %b result %h expected 0 0 0", o_Busy, o_Done, o_Result_E);
    end
    @(posedge clk); #1;
    rst = 1'b0; i_Start_E = 1'b0;
    exp_last = 32'h0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (o_Done) dones++; end
    tests_run++;
    if (dones !== 0) begin tests_failed++; $display("FAIL reset_no_done: got %0d pulses expected 0", dones); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1, res2;
    int lat1, lat2, bn1, bn2;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    do_op(3'd0, a1, b1, 1'b1, res1, lat1, bn1);
    do_op(3'd4, a2, b2, 1'b0, res2, lat2, bn2);
    tests_run++;
    if (res1 !== ref_model(3'd0, a1, b1)) begin
      tests_failed++; $display("FAIL b2b_mul: got %h expected %h", res1, ref_model(3'd0, a1, b1));
    end
    tests_run++;
    if (res2 !== ref_model(3'd4, a2, b2)) begin
      tests_failed++; $display("FAIL b2b_div: got %h expected %h", res2, ref_model(3'd4, a2, b2));
    end
    tests_run++;
    if (lat1 !== 2 || lat2 !== 33) begin
      tests_failed++; $display("FAIL b2b_latency: got %0d/%0d expected 2/33", lat1, lat2);
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_random();
    test_flush_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
